dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Two-port round-robin arbiter/sequencer in front of the single-port data memory (64 x 32b).
//  Port A = CPU load/store unit; port B = debug/DMA loader.
//  Grants one access at a time and drives the memory control/size/sign lines for exactly one cycle.
//  Returns registered read data (or a write ack) with an error flag for illegal accesses.
// PARAMETERS
//  ADDR_LIMIT  64  number of valid word addresses; addr >= ADDR_LIMIT -> error, no memory access
// PORTS
//  clk            in   1   system clock, all state on posedge
//  rst            in   1   asynchronous, active-high reset
//  a_req/b_req    in   1   request; held high with fields stable until x_rsp_valid
//  a_we/b_we      in   1   1 = store, 0 = load
//  a_addr/b_addr  in   32  word address
//  a_wdata/b_wdata in  32  store data
//  a_size/b_size  in   2   01 byte, 10 half, 11 word; 00 illegal
//  a_uns/b_uns    in   1   1 = zero-extend load (ignored for stores)
//  a_rsp_valid/b_rsp_valid out 1  one-cycle pulse: access complete
//  a_rsp_err/b_rsp_err     out 1  qualifies rsp_valid: illegal size or out-of-range address
//  a_rdata/b_rdata         out 32 load data, valid with rsp_valid; 0 for stores and errors
//  mem_addr       out  32  to memory addr
//  mem_write_data out  32  to memory write_data
//  mem_read/mem_write out 1 memory strobes; never both high
//  mem_size       out  2   to memory mem_size
//  mem_signed_unsigned out 1 to memory signed_unsigned
//  mem_read_data  in   32  from memory read_data (registered inside memory)
// BEHAVIOUR
//  Reset: state IDLE, last_grant = B (so A wins first tie), all outputs 0.
//  FSM IDLE -> ISSUE -> RESP -> IDLE; one access in flight; throughput 1 access / 3 cycles.
//  IDLE: if any req, pick winner (only one requesting -> it; both -> the one not in last_grant);
//   latch its we/addr/wdata/size/uns, set last_grant, check legality, go ISSUE. No req: stay IDLE.
//  ISSUE: legal -> drive mem_addr/wdata/size, mem_read = !we, mem_write = we for this cycle only;
//   mem_signed_unsigned = uns for loads, forced 0 for stores (memory only writes with it 0).
//   Illegal (size 00, or addr >= ADDR_LIMIT, compared on full 32b) -> no strobe. Go RESP.
//  RESP: winner's rsp_valid = 1 for one cycle; rdata = mem_read_data for legal loads, else 0;
//   rsp_err = illegal flag. Loser's outputs stay 0. Go IDLE.
//  Latency: req seen in IDLE at cycle N -> strobe in N+1 -> rsp_valid in N+2.
//  Requester must not drop req before rsp_valid; req sampled again only in IDLE, so a requester
//   re-asserting right after rsp_valid competes fairly (alternation under continuous load).
//  mem_* outputs are 0 in IDLE and RESP (addr/data 0, strobes low).
//  rst mid-access: immediate return to IDLE, strobes/rsp_valid drop asynchronously, no response sent;
//   requester must reissue.
// TESTING
//  1 Reset: rst high 2 cycles -> all outputs 0; first cycle after, A and B both req -> A granted.
//  2 A store word addr 5 data 32'hDEADBEEF, then A load word addr 5 -> rsp_valid at N+2 each,
//    mem_write for one cycle, load returns 32'hDEADBEEF, err 0.
//  3 B store byte 32'h000000F0 at addr 7; B load byte signed -> 32'hFFFFFFF0;
//    unsigned -> 32'h000000F0; stores show mem_signed_unsigned = 0.
//  4 A and B req continuously -> grants alternate A,B,A,B; each rsp every 6 cycles; never both rsp_valid.
//  5 A load addr 64 -> rsp_err 1, rdata 0, no mem strobe; B size 00 -> same.
//  6 rst asserted during ISSUE -> mem strobe and rsp_valid 0 at once; FSM IDLE after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer between the CPU load/store port (A) and the debug/DMA port (B)
// in front of the single-port data memory; one access in flight, IDLE -> ISSUE -> RESP.
module dmem_arbiter #(
    parameter int unsigned ADDR_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [1:0]  a_size,
    input  logic        a_uns,
    output logic        a_rsp_valid,
    output logic        a_rsp_err,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [1:0]  b_size,
    input  logic        b_uns,
    output logic        b_rsp_valid,
    output logic        b_rsp_err,
    output logic [31:0] b_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic        mem_signed_unsigned,
    input  logic [31:0] mem_read_data,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        last_grant;   // 0 = A, 1 = B
    logic        cur;          // port owning the access in flight
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_uns;
    logic        lat_err;

    logic        sel_b;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  sel_size;
    logic        sel_uns;
    logic        sel_err;
    logic [31:0] rsp_data;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        sel_b     = b_req && (!a_req || !last_grant);
        sel_we    = sel_b ? b_we    : a_we;
        sel_addr  = sel_b ? b_addr  : a_addr;
        sel_wdata = sel_b ? b_wdata : a_wdata;
        sel_size  = sel_b ? b_size  : a_size;
        sel_uns   = sel_b ? b_uns   : a_uns;
        sel_err   = (sel_size == 2'b00) || (sel_addr >= 32'(ADDR_LIMIT));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (a_req || b_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur        <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_size   <= 2'b00;
            lat_uns    <= 1'b0;
            lat_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (a_req || b_req)) begin
                cur        <= sel_b;
                last_grant <= sel_b;
                lat_we     <= sel_we;
                lat_addr   <= sel_addr;
                lat_wdata  <= sel_wdata;
                lat_size   <= sel_size;
                lat_uns    <= sel_uns;
                lat_err    <= sel_err;
            end
        end
    end

    // Outputs decode straight from the state register so reset clears them asynchronously.
    always_comb begin
        mem_addr            = '0;
        mem_write_data      = '0;
        mem_read            = 1'b0;
        mem_write           = 1'b0;
        mem_size            = 2'b00;
        mem_signed_unsigned = 1'b0;
        a_rsp_valid         = 1'b0;
        a_rsp_err           = 1'b0;
        a_rdata             = '0;
        b_rsp_valid         = 1'b0;
        b_rsp_err           = 1'b0;
        b_rdata             = '0;
        rsp_data            = (lat_err || lat_we) ? 32'd0 : mem_read_data;
        if (state == ISSUE && !lat_err) begin
            mem_addr            = lat_addr;
            mem_write_data      = lat_we ? lat_wdata : 32'd0;
            mem_size            = lat_size;
            mem_read            = !lat_we;
            mem_write           = lat_we;
            mem_signed_unsigned = lat_we ? 1'b0 : lat_uns;
        end
        if (state == RESP) begin
            if (cur) begin
                b_rsp_valid = 1'b1;
                b_rsp_err   = lat_err;
                b_rdata     = rsp_data;
            end else begin
                a_rsp_valid = 1'b1;
                a_rsp_err   = lat_err;
                a_rdata     = rsp_data;
            end
        end
    end

    assign dbg_state = state;

endmodule
